clk_nco_gen: RTL

CLK_NCO_GEN -- requirements
Module: clk_nco_gen

---
 rtl/clk_nco_gen.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/clk_nco_gen.sv
// ---------------------------------------------------------------------------
// clk_nco_gen -- multi-channel numerically controlled clock generator.
//
// Each channel adds its increment to a phase accumulator on every refclk
// cycle. The square-wave output is the registered MSB of the accumulator,
// optionally offset by a per-channel phase. The strobe output is the
// registered carry-out of that addition. A small FSM (SETTLE / LOCKED /
// APPLY) accepts one configuration write at a time and reports lock once
// the programmed rates have settled for LOCK_CYCLES cycles.
//
// Optional feature macro: CLK_NCO_GEN_PHASE_EN
//   defined   -> per-channel phase registers; outclk = MSB(acc + phase)
//   undefined -> no phase storage; outclk = MSB(acc); cfg_phase ignored
//
// Ports
//   refclk     in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   cfg_valid  in   configuration request present
//   cfg_ready  out  request accepted this cycle when high with cfg_valid
//   cfg_sel    in   [2:0] target channel
//   cfg_inc    in   [ACC_WIDTH-1:0] new increment
//   cfg_phase  in   [ACC_WIDTH-1:0] new phase offset
//   cfg_err    out  one-cycle pulse when the accepted cfg_sel is out of range
//   outclk     out  [NUM_CLOCKS-1:0] square-wave clock per channel
//   outclk_en  out  [NUM_CLOCKS-1:0] one-cycle pulse per accumulator wrap
//   locked     out  all channels settled at their programmed rates
// ---------------------------------------------------------------------------
module clk_nco_gen #(
  parameter int                   NUM_CLOCKS  = 2,
  parameter int                   ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 32'h0CCC_CCCD,
  parameter int                   LOCK_CYCLES = 1024
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_sel,
  input  logic [ACC_WIDTH-1:0]  cfg_inc,
  input  logic [ACC_WIDTH-1:0]  cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } state_e;

  localparam logic [15:0] LOCK_CNT    = 16'(LOCK_CYCLES);
  localparam logic [3:0]  NUM_CLK_W   = 4'(NUM_CLOCKS);

  // MSB of a modulo-2^ACC_WIDTH sum; used for the phase-offset tap.
  function automatic logic sum_msb(input logic [ACC_WIDTH-1:0] a,
                                   input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH-1:0] s;
    s = a + b;
    return s[ACC_WIDTH-1];
  endfunction

  // Control state
  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 locked_q, locked_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [2:0]           cfg_sel_q, cfg_sel_d;
  logic [ACC_WIDTH-1:0] cfg_inc_q, cfg_inc_d;
  logic                 accept_s;
  logic                 sel_bad_s;

  // Channel state
  logic [ACC_WIDTH-1:0]  acc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]  acc_d [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]  inc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]  inc_d [NUM_CLOCKS];
  logic [ACC_WIDTH:0]    sum_s [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0] outclk_en_q, outclk_en_d;

`ifdef CLK_NCO_GEN_PHASE_EN
  logic [ACC_WIDTH-1:0] phase_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0] phase_d [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0] cfg_phase_q, cfg_phase_d;
`else
  logic unused_phase_s;
  assign unused_phase_s = ^cfg_phase;
`endif

  assign accept_s  = cfg_valid & cfg_ready_q;
  assign sel_bad_s = ({1'b0, cfg_sel} >= NUM_CLK_W);

  // Next-state logic for the lock/apply FSM and captured configuration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_err_d   = 1'b0;
    cfg_sel_d   = cfg_sel_q;
    cfg_inc_d   = cfg_inc_q;
`ifdef CLK_NCO_GEN_PHASE_EN
    cfg_phase_d = cfg_phase_q;
`endif
    if (accept_s) begin
      cfg_sel_d   = cfg_sel;
      cfg_inc_d   = cfg_inc;
`ifdef CLK_NCO_GEN_PHASE_EN
      cfg_phase_d = cfg_phase;
`endif
    end else begin
      cfg_sel_d   = cfg_sel_q;
    end
    case (state_q)
      ST_SETTLE: begin
        if (accept_s) begin
          state_d   = ST_APPLY;
          cnt_d     = 16'd0;
          cfg_err_d = sel_bad_s;
        end else if ((cnt_q + 16'd1) == LOCK_CNT) begin
          state_d = ST_LOCKED;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LOCKED: begin
        if (accept_s) begin
          state_d   = ST_APPLY;
          cnt_d     = 16'd0;
          cfg_err_d = sel_bad_s;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_APPLY: begin
        // Any write (even a rejected one) forces a fresh settle period.
        state_d = ST_SETTLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = 16'd0;
      end
    endcase
    cfg_ready_d = (state_d != ST_APPLY);
    locked_d    = (state_d == ST_LOCKED);
  end

  // Per-channel accumulate, apply and output taps.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum_s[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
`ifdef CLK_NCO_GEN_PHASE_EN
      outclk_d[i] = sum_msb(acc_q[i], phase_q[i]);
`else
      outclk_d[i] = acc_q[i][ACC_WIDTH-1];
`endif
      if ((state_q == ST_APPLY) && (cfg_sel_q == 3'(i))) begin
        acc_d[i]       = '0;
        inc_d[i]       = cfg_inc_q;
        outclk_en_d[i] = 1'b0;
`ifdef CLK_NCO_GEN_PHASE_EN
        phase_d[i]     = cfg_phase_q;
`endif
      end else begin
        acc_d[i]       = sum_s[i][ACC_WIDTH-1:0];
        inc_d[i]       = inc_q[i];
        outclk_en_d[i] = sum_s[i][ACC_WIDTH];
`ifdef CLK_NCO_GEN_PHASE_EN
        phase_d[i]     = phase_q[i];
`endif
      end
    end
  end

  // Control registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= 16'd0;
      cfg_ready_q <= 1'b0;
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_sel_q   <= 3'd0;
      cfg_inc_q   <= '0;
`ifdef CLK_NCO_GEN_PHASE_EN
      cfg_phase_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      locked_q    <= locked_d;
      cfg_err_q   <= cfg_err_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_inc_q   <= cfg_inc_d;
`ifdef CLK_NCO_GEN_PHASE_EN
      cfg_phase_q <= cfg_phase_d;
`endif
    end
  end

  // Channel registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i]   <= '0;
        inc_q[i]   <= DEFAULT_INC;
`ifdef CLK_NCO_GEN_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
      outclk_q    <= '0;
      outclk_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i]   <= acc_d[i];
        inc_q[i]   <= inc_d[i];
`ifdef CLK_NCO_GEN_PHASE_EN
        phase_q[i] <= phase_d[i];
`endif
      end
      outclk_q    <= outclk_d;
      outclk_en_q <= outclk_en_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign locked    = locked_q;
  assign outclk    = outclk_q;
  assign outclk_en = outclk_en_q;

endmodule
